dbus_arb: RTL and testbench

- Round-robin arbiter and sequencer that lets several masters share the single "dbus" generic bus (for example the CPU plus a future DMA or debug master).
- Sits between the masters and the dbus master port, ahead of the address decoder and slaves.
- Runs at most one transfer at a time and forwards each transfer's ack/rdata only to the granted master.
- A bus-timeout counter releases the bus if a slave never responds.

---
 rtl/dbus_arb_if.sv | 48 ++++
 rtl/dbus_arb.sv | 160 ++++++++++++++++
 tb/tb_dbus_arb.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbus_arb_if.sv
// dbus_arb_if: bundles the master-side request/response signals and the dbus-side transfer signals.
// Latency: none, wires only.
// Backpressure: none, carries m_req/m_ack and b_req/b_ack handshakes unchanged.
// Modports:
//   master - the arbiter: drives dbus (b_*), answers the requesting masters (m_ack/m_err/m_rdata/grant).
//   slave  - the environment: drives master requests and the dbus response (b_ack/b_rdata).
// Optional: DBUS_ARB_LOCK_EN adds m_lock.
interface dbus_arb_if #(
    parameter int NMASTERS = 2,
    parameter int AW       = 8,
    parameter int DW       = 8
);
    logic [NMASTERS-1:0]    m_req;
    logic [NMASTERS-1:0]    m_we;
    logic [NMASTERS*AW-1:0] m_adr;
    logic [NMASTERS*DW-1:0] m_wdata;
    logic [NMASTERS-1:0]    m_ack;
    logic [NMASTERS-1:0]    m_err;
    logic [DW-1:0]          m_rdata;
    logic [NMASTERS-1:0]    grant;
    logic                   b_req;
    logic                   b_we;
    logic [AW-1:0]          b_adr;
    logic [DW-1:0]          b_wdata;
    logic                   b_ack;
    logic [DW-1:0]          b_rdata;
`ifdef DBUS_ARB_LOCK_EN
    logic [NMASTERS-1:0]    m_lock;

    modport master (
        input  m_lock, m_req, m_we, m_adr, m_wdata, b_ack, b_rdata,
        output m_ack, m_err, m_rdata, grant, b_req, b_we, b_adr, b_wdata
    );
    modport slave (
        output m_lock, m_req, m_we, m_adr, m_wdata, b_ack, b_rdata,
        input  m_ack, m_err, m_rdata, grant, b_req, b_we, b_adr, b_wdata
    );
`else
    modport master (
        input  m_req, m_we, m_adr, m_wdata, b_ack, b_rdata,
        output m_ack, m_err, m_rdata, grant, b_req, b_we, b_adr, b_wdata
    );
    modport slave (
        output m_req, m_we, m_adr, m_wdata, b_ack, b_rdata,
        input  m_ack, m_err, m_rdata, grant, b_req, b_we, b_adr, b_wdata
    );
`endif
endinterface

// File: rtl/dbus_arb.sv
// dbus_arb: round-robin arbiter/sequencer letting NMASTERS masters share dbus, one transfer at a time.
// Latency: b_req rises 1 cycle after m_req is sampled; m_ack/m_err pulse 1 cycle after b_ack/timeout.
// Backpressure: masters hold m_req until m_ack/m_err; dbus stalls by withholding b_ack for up to TIMEOUT cycles.
// Ports: clk, rst (async active-low), bus (dbus_arb_if.master: m_* toward masters, b_* toward dbus).
// Optional: define DBUS_ARB_LOCK_EN to add m_lock[] (owner keeps the bus for up to 4 consecutive transfers).
module dbus_arb #(
    parameter int NMASTERS = 2,
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int TIMEOUT  = 15
) (
    input  logic         clk,
    input  logic         rst,
    dbus_arb_if.master   bus
);
    localparam int         IW  = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam logic [7:0] TO8 = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                state;
    logic [NMASTERS-1:0]   grant_q;
    logic [IW-1:0]         own_q;
    logic [IW-1:0]         ptr_q;
    logic [7:0]            cnt_q;
    logic                  b_req_q;
    logic                  b_we_q;
    logic [AW-1:0]         b_adr_q;
    logic [DW-1:0]         b_wdata_q;
    logic [NMASTERS-1:0]   m_ack_q;
    logic [NMASTERS-1:0]   m_err_q;
    logic [DW-1:0]         m_rdata_q;
`ifdef DBUS_ARB_LOCK_EN
    logic                  locked_q;
    logic [1:0]            lock_run_q;
`endif

    // Cyclic search starting just after the last owner.
    logic [IW-1:0] sel_idx;
    logic          sel_vld;
    always_comb begin
        logic [IW-1:0] c;
        sel_idx = '0;
        sel_vld = 1'b0;
        c       = '0;
        for (int k = 1; k <= NMASTERS; k++) begin
            c = IW'((int'(ptr_q) + k) % NMASTERS);
            if (!sel_vld && bus.m_req[c]) begin
                sel_idx = c;
                sel_vld = 1'b1;
            end
        end
    end

    // A still-requesting locked owner overrides the round-robin choice.
    logic [IW-1:0] tgt_idx;
    logic          tgt_vld;
    logic          tgt_locked;
    always_comb begin
        tgt_idx    = sel_idx;
        tgt_vld    = sel_vld;
        tgt_locked = 1'b0;
`ifdef DBUS_ARB_LOCK_EN
        if (locked_q && bus.m_req[own_q]) begin
            tgt_idx    = own_q;
            tgt_vld    = 1'b1;
            tgt_locked = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant_q    <= '0;
            own_q      <= '0;
            ptr_q      <= IW'(NMASTERS - 1);
            cnt_q      <= '0;
            b_req_q    <= 1'b0;
            b_we_q     <= 1'b0;
            b_adr_q    <= '0;
            b_wdata_q  <= '0;
            m_ack_q    <= '0;
            m_err_q    <= '0;
            m_rdata_q  <= '0;
`ifdef DBUS_ARB_LOCK_EN
            locked_q   <= 1'b0;
            lock_run_q <= '0;
`endif
        end else begin
            // Completion strobes are single-cycle by construction.
            m_ack_q <= '0;
            m_err_q <= '0;
            case (state)
                IDLE: begin
                    cnt_q <= '0;
`ifdef DBUS_ARB_LOCK_EN
                    locked_q <= 1'b0;
                    if (!tgt_locked) lock_run_q <= '0;
`endif
                    if (tgt_vld) begin
                        grant_q          <= '0;
                        grant_q[tgt_idx] <= 1'b1;
                        own_q            <= tgt_idx;
                        b_we_q           <= bus.m_we[tgt_idx];
                        b_adr_q          <= bus.m_adr[tgt_idx*AW +: AW];
                        b_wdata_q        <= bus.m_wdata[tgt_idx*DW +: DW];
                        b_req_q          <= 1'b1;
                        state            <= XFER;
                    end else begin
                        grant_q <= '0;
                    end
                end
                XFER: begin
                    cnt_q <= cnt_q + 8'd1;
                    // b_ack is checked first so an ack in the timeout cycle still completes normally.
                    if (bus.b_ack) begin
                        m_rdata_q       <= bus.b_rdata;
                        m_ack_q[own_q]  <= 1'b1;
                        b_req_q         <= 1'b0;
                        state           <= DONE;
                    end else if (cnt_q + 8'd1 == TO8) begin
                        m_err_q[own_q]  <= 1'b1;
                        b_req_q         <= 1'b0;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    cnt_q <= '0;
                    state <= IDLE;
`ifdef DBUS_ARB_LOCK_EN
                    // Lock honoured only on a clean completion and for at most 4 transfers in a row.
                    if (bus.m_lock[own_q] && !(|m_err_q) && lock_run_q != 2'd3) begin
                        locked_q   <= 1'b1;
                        lock_run_q <= lock_run_q + 2'd1;
                    end else begin
                        locked_q   <= 1'b0;
                        lock_run_q <= '0;
                        grant_q    <= '0;
                        ptr_q      <= own_q;
                    end
`else
                    grant_q <= '0;
                    ptr_q   <= own_q;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant   = grant_q;
    assign bus.b_req   = b_req_q;
    assign bus.b_we    = b_we_q;
    assign bus.b_adr   = b_adr_q;
    assign bus.b_wdata = b_wdata_q;
    assign bus.m_ack   = m_ack_q;
    assign bus.m_err   = m_err_q;
    assign bus.m_rdata = m_rdata_q;
endmodule

// File: tb/tb_dbus_arb.sv
// tb_dbus_arb: self-checking bench for dbus_arb (3 masters, 8-bit bus, TIMEOUT 15).
// Latency: n/a.
// Backpressure: n/a.
module tb_dbus_arb;
    localparam int N  = 3;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dbus_arb_if #(.NMASTERS(N), .AW(8), .DW(8)) bus ();

    dbus_arb #(.NMASTERS(N), .AW(8), .DW(8), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef DBUS_ARB_LOCK_EN
    initial bus.m_lock = '0;
`endif

    int   n_chk  = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- dbus slave ----------------
    int         ack_dly     = -1;   // directed: b_ack in the ack_dly-th cycle of b_req (0 = first), -1 = never
    bit         rnd_slave   = 1'b0;
    int         rnd_ack_pct = 25;
    logic [7:0] rd_val      = 8'h00;
    int         sl_cnt      = 0;

    initial begin
        bus.b_ack   = 1'b0;
        bus.b_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.b_req === 1'b1) sl_cnt++; else sl_cnt = 0;
            if (rnd_slave) begin
                bus.b_ack   = ($urandom_range(0, 99) < rnd_ack_pct);
                bus.b_rdata = 8'($urandom);
            end else begin
                bus.b_ack   = (bus.b_req === 1'b1) && (ack_dly >= 0) && (sl_cnt - 1 == ack_dly);
                bus.b_rdata = rd_val;
            end
        end
    end

    // ---------------- behavioural model ----------------
    // Tracks the one outstanding transaction: who owns it and how many cycles b_req has been up.
    int               md_own;
    int               md_last;
    int               md_age;
    bit               md_busy;
    bit               md_wrap;
    logic [N-1:0]     e_grant, e_ack, e_err;
    logic             e_breq, e_bwe;
    logic [7:0]       e_badr, e_bwdata, e_rdata;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_own = -1; md_last = N - 1; md_age = 0; md_busy = 0; md_wrap = 0;
            e_grant = '0; e_ack = '0; e_err = '0; e_breq = 0; e_bwe = 0;
            e_badr = '0; e_bwdata = '0; e_rdata = '0;
        end else begin
            e_ack = '0;
            e_err = '0;
            if (md_wrap) begin
                md_wrap = 0;
                md_last = md_own;
                md_own  = -1;
                e_grant = '0;
            end else if (md_busy) begin
                md_age++;
                if (bus.b_ack) begin
                    e_ack[md_own] = 1'b1;
                    e_rdata = bus.b_rdata;
                    md_busy = 0; e_breq = 0; md_wrap = 1;
                end else if (md_age == TO) begin
                    e_err[md_own] = 1'b1;
                    md_busy = 0; e_breq = 0; md_wrap = 1;
                end
            end else begin
                int w;
                w = -1;
                for (int k = 1; k <= N; k++)
                    if (w < 0 && bus.m_req[(md_last + k) % N]) w = (md_last + k) % N;
                if (w >= 0) begin
                    md_own = w; md_busy = 1; md_age = 0;
                    e_grant = '0; e_grant[w] = 1'b1;
                    e_breq = 1; e_bwe = bus.m_we[w];
                    e_badr = bus.m_adr[w*8 +: 8]; e_bwdata = bus.m_wdata[w*8 +: 8];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant",   32'(bus.grant),   32'(e_grant));
            chk("b_req",   32'(bus.b_req),   32'(e_breq));
            chk("b_we",    32'(bus.b_we),    32'(e_bwe));
            chk("b_adr",   32'(bus.b_adr),   32'(e_badr));
            chk("b_wdata", 32'(bus.b_wdata), 32'(e_bwdata));
            chk("m_ack",   32'(bus.m_ack),   32'(e_ack));
            chk("m_err",   32'(bus.m_err),   32'(e_err));
            chk("m_rdata", 32'(bus.m_rdata), 32'(e_rdata));
            chk("resp_onehot", 32'($countones({bus.m_ack, bus.m_err}) <= 1), 32'd1);
        end
    end

    // ---------------- directed transfer helper ----------------
    // Runs until master m sees m_ack/m_err; lat counts cycles from b_req rising to the pulse.
    task automatic run_xfer(input int m, input int max, output int lat, output bit got_ack,
                            output bit got_err, output logic [7:0] rdat, output logic [N-1:0] g,
                            output logic [7:0] a, output logic [7:0] d, output bit other);
        int rise;
        rise = -1; lat = -1; got_ack = 0; got_err = 0; rdat = '0; g = '0; a = '0; d = '0; other = 0;
        for (int c = 0; c < max; c++) begin
            tick();
            if (bus.b_req && rise < 0) begin
                rise = c; g = bus.grant; a = bus.b_adr; d = bus.b_wdata;
            end
            if ((bus.m_ack & ~(N'(1) << m)) != '0) other = 1;
            if (bus.m_ack[m] || bus.m_err[m]) begin
                got_ack = bus.m_ack[m]; got_err = bus.m_err[m]; rdat = bus.m_rdata;
                lat = c - rise;
                bus.m_req[m] = 1'b0;
                return;
            end
        end
        n_chk++; n_fail++;
        $display("FAIL xfer_wait: master %0d got no m_ack/m_err within %0d cycles", m, max);
    endtask

    int           lat;
    bit           ack, err, oth;
    logic [7:0]   rdat, a, d;
    logic [N-1:0] g;
    int           seq [6];
    int           nseq;

    initial begin
        bus.m_req = '0; bus.m_we = '0; bus.m_adr = '0; bus.m_wdata = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) tick();
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_b_req", 32'(bus.b_req), 0);
        chk("rst_m_rdata", 32'(bus.m_rdata), 0);
        chk("rst_b_adr", 32'(bus.b_adr), 0);
        rst = 1'b1;
        tick();

        // Fairness from reset: masters 0 and 1 request continuously.
        ack_dly = 0;
        bus.m_req[0] = 1'b1; bus.m_req[1] = 1'b1;
        nseq = 0;
        for (int c = 0; c < 80 && nseq < 6; c++) begin
            tick();
            if (bus.m_ack != '0) begin
                seq[nseq] = bus.m_ack[2] ? 2 : (bus.m_ack[1] ? 1 : 0);
                nseq++;
            end
        end
        bus.m_req = '0;
        chk("fair_count", nseq, 6);
        for (int i = 0; i < 6; i++) chk("fair_seq", seq[i], i % 2);
        tick();

        // Single write from master 0, slave acks 2 cycles after b_req.
        ack_dly = 2;
        bus.m_we[0] = 1'b1; bus.m_adr[7:0] = 8'h12; bus.m_wdata[7:0] = 8'hA5; bus.m_req[0] = 1'b1;
        run_xfer(0, 20, lat, ack, err, rdat, g, a, d, oth);
        chk("wr_adr", 32'(a), 32'h12);
        chk("wr_wdata", 32'(d), 32'hA5);
        chk("wr_grant", 32'(g), 32'b001);
        chk("wr_lat", lat, 3);
        chk("wr_ack", 32'(ack), 1);
        tick(); tick();
        chk("wr_grant_idle", 32'(bus.grant), 0);

        // Read from master 1, data routed back with m_ack[1] only.
        ack_dly = 1; rd_val = 8'h3C;
        bus.m_we[1] = 1'b0; bus.m_adr[15:8] = 8'h40; bus.m_req[1] = 1'b1;
        run_xfer(1, 20, lat, ack, err, rdat, g, a, d, oth);
        chk("rd_adr", 32'(a), 32'h40);
        chk("rd_data", 32'(rdat), 32'h3C);
        chk("rd_ack", 32'(ack), 1);
        chk("rd_other_ack", 32'(oth), 0);
        chk("rd_grant", 32'(g), 32'b010);
        tick();

        // Timeout on master 0 while master 1 waits; master 1 served afterwards.
        ack_dly = -1;
        bus.m_req[0] = 1'b1; bus.m_req[1] = 1'b1;
        run_xfer(0, 40, lat, ack, err, rdat, g, a, d, oth);
        chk("to_lat", lat, 15);
        chk("to_err", 32'(err), 1);
        chk("to_ack", 32'(ack), 0);
        chk("to_rdata_kept", 32'(rdat), 32'h3C);
        ack_dly = 1;
        run_xfer(1, 20, lat, ack, err, rdat, g, a, d, oth);
        chk("to_next_grant", 32'(g), 32'b010);
        chk("to_next_ack", 32'(ack), 1);
        tick();

        // b_ack in the very cycle the timeout would fire: ack wins.
        ack_dly = TO - 1; rd_val = 8'h5A;
        bus.m_req[0] = 1'b1;
        run_xfer(0, 40, lat, ack, err, rdat, g, a, d, oth);
        chk("col_lat", lat, 15);
        chk("col_ack", 32'(ack), 1);
        chk("col_err", 32'(err), 0);
        chk("col_rdata", 32'(rdat), 32'h5A);
        tick();

        // Async reset mid-transfer.
        ack_dly = -1;
        bus.m_req[1] = 1'b1;
        tick();
        bus.m_req[0] = 1'b1;   // master 1 owns (pointer at 0), master 0 waits
        repeat (4) tick();
        chk("ar_b_req_before", 32'(bus.b_req), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("ar_b_req", 32'(bus.b_req), 0);
        chk("ar_grant", 32'(bus.grant), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        ack_dly = 0;
        run_xfer(0, 20, lat, ack, err, rdat, g, a, d, oth);
        chk("ar_first_grant", 32'(g), 32'b001);
        run_xfer(1, 20, lat, ack, err, rdat, g, a, d, oth);
        chk("ar_second_grant", 32'(g), 32'b010);
        tick();

        // Randomized traffic: masters come and go, slave acks at random (also outside XFER).
        rnd_slave = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rnd_ack_pct = (cyc < 2000) ? 30 : 5;
            tick();
            for (int i = 0; i < N; i++) begin
                if (bus.m_ack[i] || bus.m_err[i]) bus.m_req[i] = 1'b0;
                else if (bus.m_req[i] && $urandom_range(0, 59) == 0) bus.m_req[i] = 1'b0;
                if (!bus.m_req[i] && $urandom_range(0, 2) == 0) begin
                    bus.m_req[i] = 1'b1;
                    bus.m_we[i]  = 1'($urandom);
                end
                if ($urandom_range(0, 3) == 0) begin
                    bus.m_adr[i*8 +: 8]   = 8'($urandom);
                    bus.m_wdata[i*8 +: 8] = 8'($urandom);
                end
            end
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
